// File: rtl/vga_sync_decode.sv
// Recovers column/row position and timing lock from VGA-style active-high syncs.
// Optional error counter on o_err_count is built when VGA_SYNC_DECODE_ERRCNT_EN is defined.
module vga_sync_decode #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_hsync,
    input  logic       i_vsync,
    output logic [9:0] o_col_count,
    output logic [9:0] o_row_count,
    output logic       o_frame_start,
    output logic       o_active,
    output logic       o_locked,
    output logic [7:0] o_err_count
);

    localparam logic [9:0] COL_LAST   = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST   = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] COL_ACTIVE = 10'(ACTIVE_COLS);
    localparam logic [9:0] ROW_ACTIVE = 10'(ACTIVE_ROWS);
    localparam int         CW         = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] LOCK_TARGET = CW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] good_cnt_q, good_cnt_d;
    logic [9:0]    col_q, col_d;
    logic [9:0]    row_q, row_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          h_seen_q, h_seen_d;
    logic          v_seen_q, v_seen_d;
    logic          bad_q, bad_d;
    logic          frame_start_q, frame_start_d;
    logic          locked_q, locked_d;

    logic hs_edge, vs_edge, col_wrap, line_inc, frame_sync, row_wrap;
    logic line_err, frame_err, any_err, good_frame;

    always_comb begin
        hs_edge    = i_hsync & ~hs_q;
        vs_edge    = i_vsync & ~vs_q;
        col_wrap   = !hs_edge && (col_q == COL_LAST);
        line_inc   = hs_edge || col_wrap;
        frame_sync = hs_edge && vs_edge;
        row_wrap   = line_inc && !vs_edge && (row_q == ROW_LAST);

        line_err   = h_seen_q && ((hs_edge && (col_q != COL_LAST)) || col_wrap);
        frame_err  = v_seen_q && ((vs_edge && (!hs_edge || (row_q != ROW_LAST))) || row_wrap);
        any_err    = line_err || frame_err;
        // bad_q remembers any error since the last vsync edge
        good_frame = vs_edge && v_seen_q && !bad_q && !any_err;

        hs_d          = i_hsync;
        vs_d          = i_vsync;
        h_seen_d      = h_seen_q | hs_edge;
        v_seen_d      = v_seen_q | vs_edge;
        bad_d         = vs_edge ? 1'b0 : (bad_q | any_err);
        frame_start_d = frame_sync;

        if (hs_edge || col_wrap) begin
            col_d = 10'd0;
        end else begin
            col_d = col_q + 10'd1;
        end

        row_d = row_q;
        if (frame_sync) begin
            row_d = 10'd0;
        end else if (line_inc) begin
            row_d = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
        end

        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (vs_edge) begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = '0;
                end
            end
            ST_ACQUIRE: begin
                if (any_err) begin
                    state_d    = ST_UNLOCKED;
                    good_cnt_d = '0;
                end else if (good_frame) begin
                    if ((good_cnt_q + CW'(1)) == LOCK_TARGET) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + CW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (any_err) begin
                    state_d    = ST_UNLOCKED;
                    good_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_UNLOCKED;
                good_cnt_d = '0;
            end
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_UNLOCKED;
            good_cnt_q    <= '0;
            col_q         <= '0;
            row_q         <= '0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            bad_q         <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            bad_q         <= bad_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
        end
    end

`ifdef VGA_SYNC_DECODE_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of clocks that flagged a line and/or frame error
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (any_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_count = err_cnt_q;
`else
    assign o_err_count = 8'd0;
`endif

    assign o_col_count   = col_q;
    assign o_row_count   = row_q;
    assign o_frame_start = frame_start_q;
    assign o_locked      = locked_q;
    assign o_active      = locked_q && (col_q < COL_ACTIVE) && (row_q < ROW_ACTIVE);

endmodule

// File: tb/tb_vga_sync_decode.sv
// Scoreboard bench for vga_sync_decode using a reduced 20x10 raster so whole frames fit in a short run.
module tb_vga_sync_decode;

    localparam int TC = 20;
    localparam int TR = 10;
    localparam int AC = 16;
    localparam int AR = 8;
    localparam int TF = TC * TR;
`ifdef VGA_SYNC_DECODE_ERRCNT_EN
    localparam int ERR_STEP = 1;
`else
    localparam int ERR_STEP = 0;
`endif

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_hsync;
    logic       i_vsync;
    logic [9:0] o_col_count;
    logic [9:0] o_row_count;
    logic       o_frame_start;
    logic       o_active;
    logic       o_locked;
    logic [7:0] o_err_count;

    exp_t sbq[$];
    exp_t cur;
    int   src_col, src_row, line_len;
    bit   vs_kill, vs_kill_next, sync_off;
    int   n_cmp = 0;
    int   n_bad = 0;

    vga_sync_decode #(
        .TOTAL_COLS (TC),
        .TOTAL_ROWS (TR),
        .ACTIVE_COLS(AC),
        .ACTIVE_ROWS(AR),
        .LOCK_FRAMES(2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .o_col_count  (o_col_count),
        .o_row_count  (o_row_count),
        .o_frame_start(o_frame_start),
        .o_active     (o_active),
        .o_locked     (o_locked),
        .o_err_count  (o_err_count)
    );

    always #5 clk = ~clk;

    // Present the source position on the syncs and queue what the DUT should show one clock later
    task automatic drive_src();
        i_hsync = !sync_off && (src_col < AC);
        i_vsync = !sync_off && !vs_kill && (src_row < AR);
        sbq.push_back('{col: 10'(src_col), row: 10'(src_row),
                        fs: (src_col == 0 && src_row == 0 && !vs_kill && !sync_off)});
    endtask

    task automatic run_cycle();
        @(posedge clk);
        #1;
        if (sbq.size() > 0) cur = sbq.pop_front();
        src_col++;
        if (src_col >= line_len) begin
            src_col  = 0;
            line_len = TC;
            src_row++;
            if (src_row >= TR) begin
                src_row      = 0;
                vs_kill      = vs_kill_next;
                vs_kill_next = 1'b0;
            end
        end
        drive_src();
    endtask

    task automatic do_reset();
        i_rst        = 1'b1;
        src_col      = 0;
        src_row      = 0;
        line_len     = TC;
        vs_kill      = 1'b0;
        vs_kill_next = 1'b0;
        sbq.delete();
        drive_src();
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst   = 1'b1;
        i_hsync = 1'b1;
        i_vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 6;
        if (o_col_count !== 10'd0) begin n_bad++; $display("[TB] FAIL reset_col got %0d want 0", o_col_count); end
        if (o_row_count !== 10'd0) begin n_bad++; $display("[TB] FAIL reset_row got %0d want 0", o_row_count); end
        if (o_frame_start !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_fs got %b want 0", o_frame_start); end
        if (o_active !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_active got %b want 0", o_active); end
        if (o_locked !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_locked got %b want 0", o_locked); end
        if (o_err_count !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_err got %0d want 0", o_err_count); end
    endtask

    task automatic test_acquire();
        int  nfs;
        bit  elock, eact;
        sync_off = 1'b0;
        do_reset();
        nfs = 0;
        for (int i = 0; i < 3 * TF + 5; i++) begin
            run_cycle();
            if (cur.fs) nfs++;
            elock = (nfs >= 3);
            eact  = elock && (cur.col < AC) && (cur.row < AR);
            n_cmp += 5;
            if (o_col_count !== cur.col) begin n_bad++; $display("[TB] FAIL acq_col got %0d want %0d", o_col_count, cur.col); end
            if (o_row_count !== cur.row) begin n_bad++; $display("[TB] FAIL acq_row got %0d want %0d", o_row_count, cur.row); end
            if (o_frame_start !== cur.fs) begin n_bad++; $display("[TB] FAIL acq_fs got %b want %b", o_frame_start, cur.fs); end
            if (o_locked !== elock) begin n_bad++; $display("[TB] FAIL acq_locked cycle %0d got %b want %b", i, o_locked, elock); end
            if (o_active !== eact) begin n_bad++; $display("[TB] FAIL acq_active got %b want %b", o_active, eact); end
        end
        n_cmp++;
        if (o_err_count !== 8'd0) begin n_bad++; $display("[TB] FAIL acq_err got %0d want 0", o_err_count); end
    endtask

    task automatic test_tracking();
        int  dut_fs;
        bit  eact;
        dut_fs = 0;
        for (int i = 0; i < 1000; i++) begin
            run_cycle();
            if (o_frame_start === 1'b1) dut_fs++;
            eact = (cur.col < AC) && (cur.row < AR);
            n_cmp += 5;
            if (o_col_count !== cur.col) begin n_bad++; $display("[TB] FAIL trk_col got %0d want %0d", o_col_count, cur.col); end
            if (o_row_count !== cur.row) begin n_bad++; $display("[TB] FAIL trk_row got %0d want %0d", o_row_count, cur.row); end
            if (o_frame_start !== cur.fs) begin n_bad++; $display("[TB] FAIL trk_fs got %b want %b", o_frame_start, cur.fs); end
            if (o_locked !== 1'b1) begin n_bad++; $display("[TB] FAIL trk_locked got %b want 1", o_locked); end
            if (o_active !== eact) begin n_bad++; $display("[TB] FAIL trk_active got %b want %b", o_active, eact); end
        end
        n_cmp++;
        if (dut_fs != 5) begin n_bad++; $display("[TB] FAIL trk_fs_count got %0d want 5", dut_fs); end
    endtask

    task automatic test_stretch();
        bit hit;
        int nfs;
        for (int i = 0; i < 2 * TF && !(src_row == 3 && src_col == 5); i++) run_cycle();
        line_len = TC + 1;
        hit = 1'b0;
        for (int i = 0; i < 3 * TC && !hit; i++) begin
            run_cycle();
            if (cur.col == 10'(TC)) begin
                hit = 1'b1;
                n_cmp += 3;
                if (o_locked !== 1'b0) begin n_bad++; $display("[TB] FAIL str_drop got %b want 0", o_locked); end
                if (o_col_count !== 10'd0) begin n_bad++; $display("[TB] FAIL str_flywheel got %0d want 0", o_col_count); end
                if (o_err_count !== 8'(ERR_STEP)) begin n_bad++; $display("[TB] FAIL str_err got %0d want %0d", o_err_count, ERR_STEP); end
            end
        end
        if (!hit) begin n_cmp++; n_bad++; $display("[TB] FAIL str_timeout got no stretched column want one"); end
        nfs = 0;
        hit = 1'b0;
        for (int i = 0; i < 4 * TF && !hit; i++) begin
            run_cycle();
            if (cur.fs) begin
                nfs++;
                if (nfs == 2) begin
                    n_cmp++;
                    if (o_locked !== 1'b0) begin n_bad++; $display("[TB] FAIL str_early got %b want 0", o_locked); end
                end
                if (nfs == 3) begin
                    hit = 1'b1;
                    n_cmp += 3;
                    if (o_locked !== 1'b1) begin n_bad++; $display("[TB] FAIL str_relock got %b want 1", o_locked); end
                    if (o_col_count !== 10'd0) begin n_bad++; $display("[TB] FAIL str_col got %0d want 0", o_col_count); end
                    if (o_row_count !== 10'd0) begin n_bad++; $display("[TB] FAIL str_row got %0d want 0", o_row_count); end
                end
            end
        end
        if (!hit) begin n_cmp++; n_bad++; $display("[TB] FAIL str_relock_timeout got no relock want lock"); end
    endtask

    task automatic test_vsync_drop();
        bit         hit;
        logic [7:0] e0;
        e0           = o_err_count;
        vs_kill_next = 1'b1;
        hit          = 1'b0;
        for (int i = 0; i < 2 * TF && !hit; i++) begin
            run_cycle();
            if (cur.col == 10'(TC - 1) && cur.row == 10'(TR - 1)) begin
                n_cmp++;
                if (o_locked !== 1'b1) begin n_bad++; $display("[TB] FAIL vsd_pre got %b want 1", o_locked); end
            end
            if (cur.col == 10'd0 && cur.row == 10'd0) begin
                hit = 1'b1;
                n_cmp += 5;
                if (o_row_count !== 10'd0) begin n_bad++; $display("[TB] FAIL vsd_row got %0d want 0", o_row_count); end
                if (o_col_count !== 10'd0) begin n_bad++; $display("[TB] FAIL vsd_col got %0d want 0", o_col_count); end
                if (o_frame_start !== 1'b0) begin n_bad++; $display("[TB] FAIL vsd_fs got %b want 0", o_frame_start); end
                if (o_locked !== 1'b0) begin n_bad++; $display("[TB] FAIL vsd_locked got %b want 0", o_locked); end
                if (o_err_count !== e0 + 8'(ERR_STEP)) begin n_bad++; $display("[TB] FAIL vsd_err got %0d want %0d", o_err_count, e0 + 8'(ERR_STEP)); end
            end
        end
        if (!hit) begin n_cmp++; n_bad++; $display("[TB] FAIL vsd_timeout got no frame wrap want one"); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * TF && !hit; i++) begin
            run_cycle();
            hit = (o_locked === 1'b1);
        end
        n_cmp++;
        if (!hit) begin n_bad++; $display("[TB] FAIL rmid_relock got %b want 1", o_locked); end
        for (int i = 0; i < 2 * TF && !(cur.col == 10'd12 && cur.row == 10'd5); i++) run_cycle();
        n_cmp += 3;
        if (o_col_count !== 10'd12) begin n_bad++; $display("[TB] FAIL rmid_col got %0d want 12", o_col_count); end
        if (o_row_count !== 10'd5) begin n_bad++; $display("[TB] FAIL rmid_row got %0d want 5", o_row_count); end
        if (o_locked !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_pre_lock got %b want 1", o_locked); end
        #1;
        i_rst = 1'b1;
        #1;
        n_cmp += 6;
        if (o_col_count !== 10'd0) begin n_bad++; $display("[TB] FAIL rmid_col0 got %0d want 0", o_col_count); end
        if (o_row_count !== 10'd0) begin n_bad++; $display("[TB] FAIL rmid_row0 got %0d want 0", o_row_count); end
        if (o_frame_start !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_fs got %b want 0", o_frame_start); end
        if (o_active !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_active got %b want 0", o_active); end
        if (o_locked !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_locked got %b want 0", o_locked); end
        if (o_err_count !== 8'd0) begin n_bad++; $display("[TB] FAIL rmid_err got %0d want 0", o_err_count); end
    endtask

    task automatic test_free_run();
        int ecol, erow;
        sync_off = 1'b1;
        do_reset();
        for (int n = 1; n <= 2000; n++) begin
            run_cycle();
            ecol = n % TC;
            erow = (n / TC) % TR;
            n_cmp += 4;
            if (o_col_count !== 10'(ecol)) begin n_bad++; $display("[TB] FAIL free_col got %0d want %0d", o_col_count, ecol); end
            if (o_row_count !== 10'(erow)) begin n_bad++; $display("[TB] FAIL free_row got %0d want %0d", o_row_count, erow); end
            if (o_locked !== 1'b0) begin n_bad++; $display("[TB] FAIL free_locked got %b want 0", o_locked); end
            if (o_active !== 1'b0) begin n_bad++; $display("[TB] FAIL free_active got %b want 0", o_active); end
        end
        n_cmp++;
        if (o_err_count !== 8'd0) begin n_bad++; $display("[TB] FAIL free_err got %0d want 0", o_err_count); end
        sync_off = 1'b0;
    endtask

    initial begin
        i_rst        = 1'b1;
        i_hsync      = 1'b0;
        i_vsync      = 1'b0;
        sync_off     = 1'b0;
        vs_kill      = 1'b0;
        vs_kill_next = 1'b0;
        src_col      = 0;
        src_row      = 0;
        line_len     = TC;
        cur          = '0;
        test_reset();
        test_acquire();
        test_tracking();
        test_stretch();
        test_vsync_drop();
        test_reset_mid();
        test_acquire();
        test_free_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vga_sync_decode.md
VGA_SYNC_DECODE -- requirements
Module: vga_sync_decode

Interface
REQ-001 Parameters: TOTAL_COLS 800, line length in clocks; TOTAL_ROWS 525, frame length in lines; ACTIVE_COLS 640, visible columns; ACTIVE_ROWS 480, visible rows; LOCK_FRAMES 2, consecutive good frames required to lock.
REQ-002 Clocking: one clock, i_clk; reset is asynchronous and active-high, i_rst.
REQ-003 Ports:
- i_clk input 1: pixel clock (25 MHz).
- i_rst input 1: async active-high reset.
- i_hsync input 1: horizontal sync; high during the line's active portion; rising edge marks column 0.
- i_vsync input 1: vertical sync; high during the frame's active portion; rising edge marks row 0.
- o_col_count output 10: reconstructed column.
- o_row_count output 10: reconstructed row.
- o_frame_start output 1: one-cycle pulse at column 0, row 0.
- o_active output 1: visible-pixel qualifier.
- o_locked output 1: timing lock.
- o_err_count output 8: timing error count.

Function
REQ-004 i_hsync and i_vsync SHALL each be sampled into one register per clock; edges are detected as current sample 1 with previous sample 0.
REQ-005 On an hsync edge, o_col_count SHALL load 0 on that clock; otherwise it SHALL increment, wrapping from TOTAL_COLS-1 to 0 (flywheel).
REQ-006 On an hsync edge or a flywheel wrap, o_row_count SHALL increment, wrapping from TOTAL_ROWS-1 to 0; if a vsync edge occurs on the same clock as an hsync edge, o_row_count SHALL load 0 instead.
REQ-007 Latency: with a source driving sync from i_clk, o_col_count and o_row_count SHALL equal the source counters delayed by exactly 1 cycle.
REQ-008 o_frame_start SHALL be 1 for exactly the one cycle in which o_col_count and o_row_count become 0 due to a coincident hsync and vsync edge.
REQ-009 o_active SHALL be 1 only when o_locked = 1, o_col_count < ACTIVE_COLS and o_row_count < ACTIVE_ROWS.
REQ-010 The first hsync edge after reset SHALL set h_seen; the first vsync edge after reset SHALL set v_seen; no error is flagged before the corresponding flag is set.
REQ-011 A line error SHALL be flagged when h_seen = 1 and either an hsync edge arrives with o_col_count != TOTAL_COLS-1, or a flywheel wrap occurs without an edge.
REQ-012 A frame error SHALL be flagged when v_seen = 1 and any of the following occurs:
- a vsync edge arrives without a coincident hsync edge;
- a vsync edge arrives with o_row_count != TOTAL_ROWS-1;
- o_row_count wraps without a vsync edge.
REQ-013 A good frame is a vsync edge with v_seen = 1 and no line or frame error since the previous vsync edge.
REQ-014 The lock FSM SHALL have three states:
- UNLOCKED: first vsync edge -> ACQUIRE, good-frame count = 0.
- ACQUIRE: each good frame increments the count; count reaching LOCK_FRAMES -> LOCKED; any error -> UNLOCKED with count cleared.
- LOCKED: any error -> UNLOCKED.
REQ-015 o_locked SHALL be 1 only in LOCKED, asserted on the clock following the qualifying vsync edge.
REQ-016 If an error and a good-frame condition occur on the same clock, the error SHALL take precedence.

Reset
REQ-017 While i_rst = 1, all of the following SHALL be 0: o_col_count, o_row_count, o_frame_start, o_active, o_locked, o_err_count, the sync sample registers, h_seen, v_seen and the good-frame count; the FSM SHALL be UNLOCKED.
REQ-018 Reset asserted mid-frame SHALL take effect immediately (asynchronously); after release, reacquisition SHALL follow REQ-010 to REQ-015 from scratch.

Configuration
REQ-019 Macro VGA_SYNC_DECODE_ERRCNT_EN controls o_err_count:
- defined: o_err_count increments by 1 per clock in which a line or frame error is flagged (one increment if both occur) and saturates at 255;
- undefined: o_err_count SHALL be constant 0 and no counter is synthesised.

Verification
REQ-020 Bench SHALL cover these scenarios:
- Default-parameter sync source on i_clk, reset released: o_locked = 1 one cycle after the 3rd vsync edge; o_err_count = 0.
- Locked, 1000 cycles sampled: o_col_count and o_row_count equal the source counters delayed by 1; o_frame_start is high once per 420000 cycles.
- Locked, one line stretched to 801 clocks: o_locked drops and o_err_count = 1 (ERRCNT_EN defined); relock after 2 further good frames.
- Locked, one vsync pulse suppressed: row wraps 524 -> 0 by flywheel; frame error flagged; o_locked = 0.
- i_rst pulsed at column 300, row 200: all outputs 0 immediately, including o_locked.
- Syncs held low for 2000 cycles after reset: o_col_count free-runs 0..799 and wraps; o_locked = 0; o_err_count = 0.
